// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_e : controller states (IDLE, RUN, DONE)
//   DIV_N       : default divisor/quotient/remainder width
//   cnt_width() : step-counter width for a given N
//   p_width()   : partial-remainder width for one restoring step (N+1)
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int unsigned DIV_N = 32;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned p_width(input int unsigned n);
        return n + 1;
    endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Operand / result handshake bundle for seq_restoring_divider.
//   in_valid, in_ready, dividend (2N), divisor (N)          : operand side
//   out_valid, out_ready, quotient, remainder, div_zero,
//   overflow                                                : result side
// Modports: slave = divider side, master = producer/consumer side.
interface div_if #(
    parameter int unsigned N = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     quotient;
    logic [N-1:0]     remainder;
    logic             div_zero;
    logic             overflow;

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero, overflow
    );

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero, overflow
    );
endinterface

// File: rtl/seq_restoring_divider_step.sv
// div_step: one combinational restoring-division step.
//   rem_in  (N) : current partial remainder, always < divisor
//   bit_in  (1) : next dividend bit shifted in
//   divisor (N) : divisor
//   rem_out (N) : new partial remainder
//   q_bit   (1) : quotient bit produced by this step
module div_step
    import div_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_out,
    output logic         q_bit
);

    logic [p_width(N)-1:0] p;

    always_comb begin
        p       = {rem_in, bit_in};
        q_bit   = (p >= {1'b0, divisor});
        // When the subtract is taken the result is < divisor, so the
        // low N bits of P minus divisor (mod 2^N) are exact.
        rem_out = q_bit ? (p[N-1:0] - divisor) : p[N-1:0];
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: unsigned 2N/N sequential restoring divider.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : div_if.slave handshake bundle (operands in, results out)
// Flagged results finish one edge after accept: divisor zero gives
// quotient all-ones / remainder = dividend low half; a quotient that
// would not fit in N bits gives quotient all-ones / remainder 0.
// Build option: DIV_RADIX4_EN chains two restoring steps per cycle.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned N = DIV_N
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);

    localparam int unsigned CW = cnt_width(N);
`ifdef DIV_RADIX4_EN
    localparam logic [CW-1:0] CNT_START = CW'(N/2 - 1);
`else
    localparam logic [CW-1:0] CNT_START = CW'(N - 1);
`endif

    div_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  rem_q,   rem_d;
    logic [N-1:0]  qsh_q,   qsh_d;
    logic [N-1:0]  dvsr_q,  dvsr_d;
    logic          div_zero_q, div_zero_d;
    logic          overflow_q, overflow_d;

    logic [N-1:0]  hi_half;
    logic [N-1:0]  lo_half;

    logic [N-1:0]  step0_rem;
    logic          step0_q;
`ifdef DIV_RADIX4_EN
    logic [N-1:0]  step1_rem;
    logic          step1_q;
`endif

    assign hi_half = bus.dividend[2*N-1:N];
    assign lo_half = bus.dividend[N-1:0];

    div_step #(.N(N)) u_step0 (
        .rem_in  (rem_q),
        .bit_in  (qsh_q[N-1]),
        .divisor (dvsr_q),
        .rem_out (step0_rem),
        .q_bit   (step0_q)
    );

`ifdef DIV_RADIX4_EN
    div_step #(.N(N)) u_step1 (
        .rem_in  (step0_rem),
        .bit_in  (qsh_q[N-2]),
        .divisor (dvsr_q),
        .rem_out (step1_rem),
        .q_bit   (step1_q)
    );
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rem_d      = rem_q;
        qsh_d      = qsh_q;
        dvsr_d     = dvsr_q;
        div_zero_d = div_zero_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                // in_ready is state==IDLE gated by rst; with rst high the
                // flops are held in reset, so only in_valid matters here.
                if (bus.in_valid) begin
                    state_d = DONE;
                    if (bus.divisor == '0) begin
                        div_zero_d = 1'b1;
                        overflow_d = 1'b0;
                        qsh_d      = '1;
                        rem_d      = lo_half;
                    end else if (hi_half >= bus.divisor) begin
                        div_zero_d = 1'b0;
                        overflow_d = 1'b1;
                        qsh_d      = '1;
                        rem_d      = '0;
                    end else begin
                        state_d    = RUN;
                        div_zero_d = 1'b0;
                        overflow_d = 1'b0;
                        rem_d      = hi_half;
                        qsh_d      = lo_half;
                        dvsr_d     = bus.divisor;
                        count_d    = CNT_START;
                    end
                end
            end

            RUN: begin
                // qsh doubles as the dividend-bit source (MSB end) and the
                // quotient accumulator (LSB end).
`ifdef DIV_RADIX4_EN
                rem_d = step1_rem;
                qsh_d = {qsh_q[N-3:0], step0_q, step1_q};
`else
                rem_d = step0_rem;
                qsh_d = {qsh_q[N-2:0], step0_q};
`endif
                if (count_q == '0) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rem_q      <= '0;
            qsh_q      <= '0;
            dvsr_q     <= '0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            qsh_q      <= qsh_d;
            dvsr_q     <= dvsr_d;
            div_zero_q <= div_zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.quotient  = qsh_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Testbench for seq_restoring_divider (N=32): directed and random
// divisions checked by a scoreboard against an arithmetic reference.
module tb_seq_restoring_divider;

    localparam int unsigned N = 32;
`ifdef DIV_RADIX4_EN
    localparam int unsigned LAT = N / 2;
`else
    localparam int unsigned LAT = N;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_if #(.N(N)) bus ();

    seq_restoring_divider #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ov;
        longint       lat;   // edges from accept edge to the edge raising out_valid
        longint       acc;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    // Reference: plain unsigned 2N/N division with the flag rules.
    function automatic exp_t model(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs);
        exp_t         e;
        logic [2*N-1:0] q64;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        e.lat = LAT;
        e.acc = 0;
        if (dvs == 0) begin
            e.dz  = 1'b1;
            e.q   = '1;
            e.r   = dvd[N-1:0];
            e.lat = 0;
        end else if (dvd[2*N-1:N] >= dvs) begin
            e.ov  = 1'b1;
            e.q   = '1;
            e.r   = '0;
            e.lat = 0;
        end else begin
            q64 = dvd / {{N{1'b0}}, dvs};
            e.q = q64[N-1:0];
            e.r = N'(dvd % {{N{1'b0}}, dvs});
        end
        return e;
    endfunction

    task automatic send(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs);
        exp_t e;
        @(negedge clk);
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (bus.in_ready) begin
                e     = model(dvd, dvs);
                e.acc = cyc + 1;
                sb.push_back(e);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                // Scramble operands: the divider must have latched them.
                bus.dividend = {$urandom, $urandom};
                bus.divisor  = $urandom;
                return;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        fail_now("accept");
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) return;
        end
        fail_now("drain");
    endtask

    // Monitor: pops one expectation when a result first appears, then
    // checks it holds steady until consumed.
    logic         seen = 1'b0;
    logic [N-1:0] held_q, held_r;
    exp_t         m;

    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            if (!seen) begin
                seen   = 1'b1;
                held_q = bus.quotient;
                held_r = bus.remainder;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got q=%0h r=%0h with nothing expected", bus.quotient, bus.remainder);
                end else begin
                    m = sb.pop_front();
                    chk("quotient",  bus.quotient,  m.q);
                    chk("remainder", bus.remainder, m.r);
                    chk("div_zero",  bus.div_zero,  m.dz);
                    chk("overflow",  bus.overflow,  m.ov);
                    chk("latency",   cyc - m.acc,   m.lat);
                end
            end else begin
                chk("hold_quotient",  bus.quotient,  held_q);
                chk("hold_remainder", bus.remainder, held_r);
            end
            chk("in_ready_in_done", bus.in_ready, 1'b0);
        end else begin
            seen = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [N-1:0]   rd;
    logic [N-1:0]   rh;
    logic           b_done;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.dividend  = '0;
        bus.divisor   = '0;
        b_done        = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready",  bus.in_ready,  1'b0);
        chk("rst_quotient",  bus.quotient,  '0);
        chk("rst_remainder", bus.remainder, '0);
        chk("rst_div_zero",  bus.div_zero,  1'b0);
        chk("rst_overflow",  bus.overflow,  1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", bus.in_ready, 1'b1);

        // Directed cases
        send(64'd100, 32'd7);                                     drain();
        send(64'h0000_0001_0000_0000, 32'd0);                     drain();
        send(64'h0000_0005_0000_0000, 32'd5);                     drain();
        send(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);             drain();
        send(64'd0, 32'd3);                                       drain();
        send(64'h0000_0000_DEAD_BEEF, 32'd1);                     drain();
        send(64'h0000_0000_FFFF_FFFF, 32'hFFFF_FFFF);             drain();
        send(64'h1234_5678_9ABC_DEF0, 32'h1234_5678);             drain();
        send(64'h0000_0000_1234_5678, 32'd0);                     drain();

        // Random in-range divisions
        for (int i = 0; i < 30; i++) begin
            rd = $urandom;
            if (rd == 0) rd = 32'd1;
            rh = $urandom % rd;
            send({rh, 32'($urandom)}, rd);
            drain();
        end

        // Random operands, some flagged
        for (int i = 0; i < 10; i++) begin
            rd = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 255));
            send({32'($urandom_range(0, 511)), 32'($urandom)}, rd);
            drain();
        end

        // Backpressure: hold result, pending operands must wait
        bus.out_ready = 1'b0;
        send(64'd5000, 32'd7);
        fork
            begin
                send(64'd777, 32'd5);
                b_done = 1'b1;
            end
        join_none
        for (int i = 0; i < 200 && !bus.out_valid; i++) @(negedge clk);
        if (!bus.out_valid) fail_now("bp_out_valid");
        repeat (10) begin
            @(negedge clk);
            chk("bp_out_valid_held", bus.out_valid, 1'b1);
            chk("bp_pending_not_accepted", 64'(sb.size()), 64'd0);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 400 && !b_done; i++) @(negedge clk);
        if (!b_done) fail_now("bp_pending_accept");
        drain();

        // Reset in the middle of RUN aborts without a result
        send(64'd123456789, 32'd97);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_out_valid", bus.out_valid, 1'b0);
        chk("abort_in_ready",  bus.in_ready,  1'b0);
        chk("abort_quotient",  bus.quotient,  '0);
        chk("abort_remainder", bus.remainder, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready_release", bus.in_ready, 1'b1);
        send(64'd1000, 32'd10);
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
